// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS control unit: FSM state
//   encoding, opcode/funct constants, instruction classes, ALU op codes and
//   the PC source select values.
//   Optional feature macro: CU_MULDIV_EN (MULTU/DIVU support, see mc_ctrl_fsm).
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

  localparam int ALU_OP_W = 6;

  // State encoding is visible on state_o, so the values are fixed.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_MULDIV = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  // Instruction class captured in DECODE; CL_ILL is the reset value.
  typedef enum logic [3:0] {
    CL_ILL  = 4'd0,
    CL_RALU = 4'd1,
    CL_IALU = 4'd2,
    CL_LW   = 4'd3,
    CL_SW   = 4'd4,
    CL_BEQ  = 4'd5,
    CL_BNE  = 4'd6,
    CL_J    = 4'd7,
    CL_MD   = 4'd8
  } class_t;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_NOP  = 6'd0;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 6'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 6'd2;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 6'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 6'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 6'd5;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 6'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 6'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 6'd8;
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = 6'd9;

  // PC source select
  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  // Classes that go through the MEM state after EXEC.
  function automatic logic is_mem(input class_t c);
    return (c == CL_LW) || (c == CL_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mc_ctrl_decode
//   Purely combinational instruction decoder.
//   Ports:
//     instr  in   32        IR word
//     cls    out  class_t   instruction class (CL_ILL when unrecognised)
//     aluop  out  ALU_OP_W  ALU operation used in EXEC
//     valid  out  1         instruction is supported
//   Macro CU_MULDIV_EN: when defined MULTU/DIVU decode to CL_MD, otherwise
//   they are treated as illegal.
// -----------------------------------------------------------------------------
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0]         instr,
  output class_t              cls,
  output logic [ALU_OP_W-1:0] aluop,
  output logic                valid
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  // Register fields and immediates are the datapath's business.
  assign unused_instr_bits = ^instr[25:6];

  always_comb begin
    cls   = CL_ILL;
    aluop = ALU_NOP;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: begin cls = CL_RALU; aluop = ALU_ADD;  end
          FN_SUB, FN_SUBU: begin cls = CL_RALU; aluop = ALU_SUB;  end
          FN_AND:          begin cls = CL_RALU; aluop = ALU_AND;  end
          FN_OR:           begin cls = CL_RALU; aluop = ALU_OR;   end
          FN_XOR:          begin cls = CL_RALU; aluop = ALU_XOR;  end
          FN_NOR:          begin cls = CL_RALU; aluop = ALU_NOR;  end
          FN_SLT:          begin cls = CL_RALU; aluop = ALU_SLT;  end
          FN_SLTU:         begin cls = CL_RALU; aluop = ALU_SLTU; end
          FN_MULTU, FN_DIVU: begin
`ifdef CU_MULDIV_EN
            cls = CL_MD;
`else
            cls = CL_ILL;
`endif
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin cls = CL_IALU; aluop = ALU_ADD;  end
      OP_SLTI:           begin cls = CL_IALU; aluop = ALU_SLT;  end
      OP_SLTIU:          begin cls = CL_IALU; aluop = ALU_SLTU; end
      OP_ANDI:           begin cls = CL_IALU; aluop = ALU_AND;  end
      OP_ORI:            begin cls = CL_IALU; aluop = ALU_OR;   end
      OP_XORI:           begin cls = CL_IALU; aluop = ALU_XOR;  end
      OP_LUI:            begin cls = CL_IALU; aluop = ALU_LUI;  end
      OP_LW:             begin cls = CL_LW;   aluop = ALU_ADD;  end
      OP_SW:             begin cls = CL_SW;   aluop = ALU_ADD;  end
      // Branches compare by subtraction; the ALU zero flag decides.
      OP_BEQ:            begin cls = CL_BEQ;  aluop = ALU_SUB;  end
      OP_BNE:            begin cls = CL_BNE;  aluop = ALU_SUB;  end
      OP_J:              begin cls = CL_J;    aluop = ALU_NOP;  end
      default: ;
    endcase
  end

  assign valid = (cls != CL_ILL);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
//   Multi-cycle MIPS control unit. Sequences FETCH/DECODE/EXEC/MEM/WB, drives
//   datapath enables and a req/ack memory handshake, runs MULTU/DIVU through
//   a MULDIV wait state with timeout, and traps on illegal instructions.
//   Ports:
//     clk, rst              clock / synchronous active-high reset
//     instr                 IR contents
//     mem_ack               memory done (only looked at while mem_req=1)
//     zero                  ALU zero flag (used in EXEC for branches)
//     md_done               mul/div unit finished pulse
//     mem_req, mem_wr       memory request / write qualifier
//     ir_we, pc_we, pc_src  IR load, PC load and PC source select
//     regdst, regwr         destination select / register file write
//     alusrc, memtoreg      ALU B-operand select / write-back source
//     aluop                 ALU operation
//     md_start              start pulse to mul/div unit
//     illegal               trap flag, held until reset
//     state_o               current state (debug)
//   Macro CU_MULDIV_EN: enables the MULTU/DIVU path and MULDIV counter; when
//   undefined those instructions trap and md_start stays 0.
//   Outputs are decoded combinationally from the state, the registered class
//   and (in FETCH/DECODE/EXEC) the live inputs; all are forced to 0 during rst.
// -----------------------------------------------------------------------------
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 6,
  parameter int MD_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               mem_ack,
  input  logic               zero,
  input  logic               md_done,
  output logic               mem_req,
  output logic               mem_wr,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               regdst,
  output logic               regwr,
  output logic               alusrc,
  output logic               memtoreg,
  output logic [ALUOP_W-1:0] aluop,
  output logic               md_start,
  output logic               illegal,
  output logic [2:0]         state_o
);

  state_t              state_reg;
  class_t              cls_reg;
  logic [ALU_OP_W-1:0] aluop_reg;
  logic [ALU_OP_W-1:0] aluop_int;

  class_t              dec_cls;
  logic [ALU_OP_W-1:0] dec_aluop;
  logic                dec_valid;

`ifdef CU_MULDIV_EN
  // Wide enough to hold MD_TIMEOUT-1 for any MD_TIMEOUT >= 1.
  localparam int CNT_W = $clog2(MD_TIMEOUT + 1);
  logic [CNT_W-1:0] md_cnt_reg;
`else
  logic unused_md_done;
  assign unused_md_done = md_done;
`endif

  mc_ctrl_decode u_decode (
    .instr (instr),
    .cls   (dec_cls),
    .aluop (dec_aluop),
    .valid (dec_valid)
  );

  // State, class and MULDIV counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_FETCH;
      cls_reg    <= CL_ILL;
      aluop_reg  <= ALU_NOP;
`ifdef CU_MULDIV_EN
      md_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (mem_ack) state_reg <= ST_DECODE;
        end
        ST_DECODE: begin
          cls_reg   <= dec_cls;
          aluop_reg <= dec_aluop;
          if (!dec_valid) begin
            state_reg <= ST_TRAP;
          end else begin
            case (dec_cls)
              CL_J: state_reg <= ST_FETCH;
`ifdef CU_MULDIV_EN
              CL_MD: begin
                state_reg  <= ST_MULDIV;
                md_cnt_reg <= '0;
              end
`endif
              default: state_reg <= ST_EXEC;
            endcase
          end
        end
        ST_EXEC: begin
          if (cls_reg == CL_RALU || cls_reg == CL_IALU) state_reg <= ST_WB;
          else if (is_mem(cls_reg))                     state_reg <= ST_MEM;
          else                                          state_reg <= ST_FETCH;
        end
        ST_MEM: begin
          if (mem_ack) state_reg <= (cls_reg == CL_LW) ? ST_WB : ST_FETCH;
        end
        ST_WB: state_reg <= ST_FETCH;
        ST_MULDIV: begin
`ifdef CU_MULDIV_EN
          // md_done takes priority over the timeout in the same cycle.
          if (md_done)                                    state_reg  <= ST_FETCH;
          else if (md_cnt_reg == CNT_W'(MD_TIMEOUT - 1))  state_reg  <= ST_TRAP;
          else                                            md_cnt_reg <= md_cnt_reg + 1'b1;
`else
          state_reg <= ST_TRAP;
`endif
        end
        ST_TRAP: state_reg <= ST_TRAP;
        default: state_reg <= ST_TRAP;
      endcase
    end
  end

  // Output decode. Wait states naturally hold outputs because nothing here
  // changes until mem_ack arrives.
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SEQ;
    regdst    = 1'b0;
    regwr     = 1'b0;
    alusrc    = 1'b0;
    memtoreg  = 1'b0;
    aluop_int = ALU_NOP;
    md_start  = 1'b0;
    illegal   = 1'b0;
    state_o   = 3'd0;
    if (!rst) begin
      state_o = state_reg;
      case (state_reg)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        ST_DECODE: begin
          if (dec_cls == CL_J) begin
            pc_we  = 1'b1;
            pc_src = PC_JMP;
          end
`ifdef CU_MULDIV_EN
          if (dec_cls == CL_MD) md_start = 1'b1;
`endif
        end
        ST_EXEC: begin
          aluop_int = aluop_reg;
          alusrc    = (cls_reg == CL_IALU) || is_mem(cls_reg);
          if (cls_reg == CL_BEQ || cls_reg == CL_BNE) begin
            pc_src = PC_BR;
            pc_we  = (cls_reg == CL_BEQ) ? zero : ~zero;
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_wr  = (cls_reg == CL_SW);
        end
        ST_WB: begin
          regwr    = 1'b1;
          memtoreg = (cls_reg == CL_LW);
          regdst   = (cls_reg == CL_RALU);
        end
        ST_TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign aluop = ALUOP_W'(aluop_int);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        mem_ack = 1'b0, zero = 1'b0, md_done = 1'b0;
  logic        mem_req, mem_wr, ir_we, pc_we, regdst, regwr, alusrc, memtoreg;
  logic        md_start, illegal;
  logic [1:0]  pc_src;
  logic [5:0]  aluop;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_errors = 0;

`ifdef CU_MULDIV_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif
  localparam int MD_LIMIT = 64;

  localparam int K_RALU = 0, K_IALU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                 K_BNE = 5, K_J = 6, K_MD = 7, K_ILL = 8;

  localparam logic [5:0] R_FN [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                       6'h26, 6'h27, 6'h2A, 6'h2B, 6'h19, 6'h1B, 6'h3F};
  localparam logic [5:0] I_OP [14] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                       6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.ALUOP_W(6), .MD_TIMEOUT(MD_LIMIT)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ack(mem_ack), .zero(zero),
    .md_done(md_done), .mem_req(mem_req), .mem_wr(mem_wr), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .regdst(regdst), .regwr(regwr),
    .alusrc(alusrc), .memtoreg(memtoreg), .aluop(aluop), .md_start(md_start),
    .illegal(illegal), .state_o(state_o)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Instruction semantics from the ISA tables: class and ALU function.
  function automatic void ref_decode(input logic [31:0] w, output int kind,
                                     output logic [5:0] aop);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    kind = K_ILL;
    aop  = ALU_NOP;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: begin kind = K_RALU; aop = ALU_ADD;  end
        6'h22, 6'h23: begin kind = K_RALU; aop = ALU_SUB;  end
        6'h24:        begin kind = K_RALU; aop = ALU_AND;  end
        6'h25:        begin kind = K_RALU; aop = ALU_OR;   end
        6'h26:        begin kind = K_RALU; aop = ALU_XOR;  end
        6'h27:        begin kind = K_RALU; aop = ALU_NOR;  end
        6'h2A:        begin kind = K_RALU; aop = ALU_SLT;  end
        6'h2B:        begin kind = K_RALU; aop = ALU_SLTU; end
        6'h19, 6'h1B: kind = MD_ON ? K_MD : K_ILL;
        default: ;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin kind = K_IALU; aop = ALU_ADD;  end
        6'h0A:        begin kind = K_IALU; aop = ALU_SLT;  end
        6'h0B:        begin kind = K_IALU; aop = ALU_SLTU; end
        6'h0C:        begin kind = K_IALU; aop = ALU_AND;  end
        6'h0D:        begin kind = K_IALU; aop = ALU_OR;   end
        6'h0E:        begin kind = K_IALU; aop = ALU_XOR;  end
        6'h0F:        begin kind = K_IALU; aop = ALU_LUI;  end
        6'h23:        begin kind = K_LW;   aop = ALU_ADD;  end
        6'h2B:        begin kind = K_SW;   aop = ALU_ADD;  end
        6'h04:        begin kind = K_BEQ;  aop = ALU_SUB;  end
        6'h05:        begin kind = K_BNE;  aop = ALU_SUB;  end
        6'h02:        kind = K_J;
        default: ;
      endcase
    end
  endfunction

  // One clock cycle: inputs to apply and the outputs required in that cycle.
  typedef struct {
    logic [31:0] instr;
    logic        ack, zero, done;
    logic        req, wr, irwe, pcwe;
    logic [1:0]  pcsrc;
    logic        rdst, rwr, asrc, m2r;
    logic [5:0]  aop;
    logic        mds, ill;
    logic [2:0]  st;
  } cyc_t;

  cyc_t plan[$];

  function automatic cyc_t blank(input logic [31:0] w, input logic z,
                                 input logic [2:0] st, input bit noise);
    cyc_t c;
    c.instr = w;  c.zero = z;  c.done = 1'b0;
    // Stray acks outside memory cycles must be ignored by the DUT.
    c.ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    c.req = 0; c.wr = 0; c.irwe = 0; c.pcwe = 0; c.pcsrc = 2'd0;
    c.rdst = 0; c.rwr = 0; c.asrc = 0; c.m2r = 0; c.aop = 6'd0;
    c.mds = 0; c.ill = 0; c.st = st;
    return c;
  endfunction

  function automatic void push_trap(input logic [31:0] w);
    cyc_t c;
    for (int i = 0; i < 3; i++) begin
      c = blank(w, 1'b0, 3'd6, 1'b1);
      c.ill = 1'b1;
      plan.push_back(c);
    end
  endfunction

  // Builds the cycle-by-cycle trace of one instruction. fw/mw = wait cycles
  // before ack in fetch/mem; mdd = MULDIV cycle (1-based) of md_done, 0 = never.
  // Returns 1 when the instruction ends in the trap state.
  function automatic bit plan_instr(input logic [31:0] w, input logic z, input int fw,
                                    input int mw, input int mdd, input bit noise);
    cyc_t c;
    int kind;
    logic [5:0] aop;
    ref_decode(w, kind, aop);
    for (int i = 0; i <= fw; i++) begin
      c = blank(w, z, 3'd0, 1'b0);
      c.req = 1'b1;
      c.ack = (i == fw);
      c.irwe = c.ack;
      c.pcwe = c.ack;
      plan.push_back(c);
    end
    c = blank(w, z, 3'd1, noise);
    if (kind == K_J) begin
      c.pcwe = 1'b1; c.pcsrc = 2'd2;
      plan.push_back(c);
      return 1'b0;
    end
    if (kind == K_MD) begin
      c.mds = 1'b1;
      plan.push_back(c);
      for (int k = 1; k <= MD_LIMIT; k++) begin
        c = blank(w, z, 3'd5, noise);
        c.done = (k == mdd);
        plan.push_back(c);
        if (c.done) return 1'b0;
      end
      push_trap(w);
      return 1'b1;
    end
    plan.push_back(c);
    if (kind == K_ILL) begin
      push_trap(w);
      return 1'b1;
    end
    c = blank(w, z, 3'd2, noise);
    c.aop  = aop;
    c.asrc = (kind == K_IALU || kind == K_LW || kind == K_SW);
    if (kind == K_BEQ || kind == K_BNE) begin
      c.pcsrc = 2'd1;
      c.pcwe  = (kind == K_BEQ) ? z : !z;
      plan.push_back(c);
      return 1'b0;
    end
    plan.push_back(c);
    if (kind == K_LW || kind == K_SW) begin
      for (int i = 0; i <= mw; i++) begin
        c = blank(w, z, 3'd3, 1'b0);
        c.req = 1'b1;
        c.wr  = (kind == K_SW);
        c.ack = (i == mw);
        plan.push_back(c);
      end
      if (kind == K_SW) return 1'b0;
    end
    c = blank(w, z, 3'd4, noise);
    c.rwr  = 1'b1;
    c.m2r  = (kind == K_LW);
    c.rdst = (kind == K_RALU);
    plan.push_back(c);
    return 1'b0;
  endfunction

  function automatic logic [20:0] dut_outs();
    return {mem_req, mem_wr, ir_we, pc_we, pc_src, regdst, regwr, alusrc,
            memtoreg, aluop, md_start, illegal, state_o};
  endfunction

  function automatic logic [20:0] exp_outs(input cyc_t c);
    return {c.req, c.wr, c.irwe, c.pcwe, c.pcsrc, c.rdst, c.rwr, c.asrc,
            c.m2r, c.aop, c.mds, c.ill, c.st};
  endfunction

  // ---------------- drivers / checkers ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic run_plan(input string tag);
    cyc_t c;
    logic [20:0] got, want;
    int n = 0;
    logic [31:0] w = 32'h0;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      w = c.instr;
      instr = c.instr; mem_ack = c.ack; zero = c.zero; md_done = c.done;
      #1;
      got  = dut_outs();
      want = exp_outs(c);
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL %s cycle %0d: outputs got %h want %h", tag, n, got, want);
      end
      n++;
      @(posedge clk); #1;
    end
    md_done = 1'b0;
    $display("txn %s instr=%08h cycles=%0d", tag, w, n);
  endtask

  task automatic do_reset(input logic ack_val, input int ncyc);
    rst = 1'b1; mem_ack = ack_val; md_done = 1'b0; zero = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      #1;
      chk("outputs_during_rst", int'(dut_outs()), 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; mem_ack = 1'b0;
  endtask

  // Directed table: ack always immediate, check latency and key strobes.
  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int          len;
    bit          rwr, rdst, m2r, br, jmp, trap;
  } dvec_t;
  dvec_t dv[10];

  task automatic run_dvec(input int idx);
    dvec_t v;
    int len = -1;
    bit rwr = 0, rdst = 0, m2r = 0, br = 0, jmp = 0, trap = 0;
    v = dv[idx];
    instr = v.instr; zero = v.zero; mem_ack = 1'b1; md_done = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (cyc > 0 && state_o == 3'd0) begin len = cyc; break; end
      if (state_o == 3'd6) begin trap = 1; len = cyc; break; end
      rwr  |= regwr;
      rdst |= regdst;
      m2r  |= memtoreg;
      br   |= pc_we && (pc_src == 2'd1);
      jmp  |= pc_we && (pc_src == 2'd2);
      @(posedge clk); #1;
    end
    chk($sformatf("dv%0d_len", idx), len, v.len);
    chk($sformatf("dv%0d_regwr", idx), int'(rwr), int'(v.rwr));
    chk($sformatf("dv%0d_regdst", idx), int'(rdst), int'(v.rdst));
    chk($sformatf("dv%0d_memtoreg", idx), int'(m2r), int'(v.m2r));
    chk($sformatf("dv%0d_branch_taken", idx), int'(br), int'(v.br));
    chk($sformatf("dv%0d_jump", idx), int'(jmp), int'(v.jmp));
    chk($sformatf("dv%0d_trap", idx), int'(trap), int'(v.trap));
    if (trap) begin
      // Trap is sticky and stays off the memory bus even with acks present.
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #2;
        chk($sformatf("dv%0d_illegal_sticky", idx), int'(illegal), 1);
        chk($sformatf("dv%0d_trap_no_req", idx), int'(mem_req), 0);
      end
      @(posedge clk); #1;
    end
    $display("txn dv%0d instr=%08h len=%0d trap=%0d", idx, v.instr, len, trap);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) < 4)
      return {6'h00, r[25:6], R_FN[$urandom_range(0, 12)]};
    return {I_OP[$urandom_range(0, 13)], r[25:0]};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    bit tr;
    logic [31:0] w;

    dv[0] = '{32'h00851021, 1'b0, 4, 1, 1, 0, 0, 0, 0};  // ADDU
    dv[1] = '{32'h8D280004, 1'b0, 5, 1, 0, 1, 0, 0, 0};  // LW
    dv[2] = '{32'hAD280004, 1'b0, 4, 0, 0, 0, 0, 0, 0};  // SW
    dv[3] = '{32'h11090003, 1'b1, 3, 0, 0, 0, 1, 0, 0};  // BEQ taken
    dv[4] = '{32'h11090003, 1'b0, 3, 0, 0, 0, 0, 0, 0};  // BEQ not taken
    dv[5] = '{32'h15090003, 1'b1, 3, 0, 0, 0, 0, 0, 0};  // BNE not taken
    dv[6] = '{32'h15090003, 1'b0, 3, 0, 0, 0, 1, 0, 0};  // BNE taken
    dv[7] = '{32'h08000010, 1'b0, 2, 0, 0, 0, 0, 1, 0};  // J
    dv[8] = '{32'h350800FF, 1'b0, 4, 1, 0, 0, 0, 0, 0};  // ORI
    dv[9] = '{32'hFC000000, 1'b0, 2, 0, 0, 0, 0, 0, 1};  // illegal opcode

    @(posedge clk); #1;
    do_reset(1'b0, 2);

    for (int i = 0; i < 10; i++) begin
      run_dvec(i);
      do_reset(1'b0, 1);
    end

    // ADDU with immediate acks, full trace.
    tr = plan_instr(32'h00851021, 1'b0, 0, 0, 0, 1'b0);
    run_plan("addu");
    // LW with 3 memory wait states: mem_req held 4 cycles in MEM.
    tr = plan_instr(32'h8D280004, 1'b0, 1, 3, 0, 1'b0);
    run_plan("lw_wait3");
    // MULTU finishing after 10 cycles, then never finishing.
    tr = plan_instr(32'h00850019, 1'b0, 0, 0, 10, 1'b1);
    run_plan("multu_done10");
    if (tr) do_reset(1'b0, 1);
    tr = plan_instr(32'h00850019, 1'b0, 0, 0, 0, 1'b0);
    run_plan("multu_timeout");
    if (tr) do_reset(1'b0, 1);
    // DIVU with md_done exactly on the last allowed cycle: done wins.
    tr = plan_instr(32'h0085001B, 1'b0, 0, 0, MD_LIMIT, 1'b0);
    run_plan("divu_done_at_limit");
    if (tr) do_reset(1'b0, 1);

    // Reset in the middle of an SW memory wait, with ack asserted under rst.
    tr = plan_instr(32'hAD280004, 1'b0, 0, 4, 0, 1'b0);
    while (plan.size() > 5) void'(plan.pop_back());
    run_plan("sw_pre_rst");
    do_reset(1'b1, 1);
    tr = plan_instr(32'h00851021, 1'b0, 0, 0, 0, 1'b0);
    run_plan("addu_after_rst");

    // Randomized instructions, wait states and flags.
    for (int t = 0; t < 80; t++) begin
      w  = rand_instr();
      tr = plan_instr(w, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12), 1'b1);
      run_plan($sformatf("rand%0d", t));
      if (tr) do_reset(1'b0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
